// File: rtl/layer_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer_io_pkg
//  Description : Shared types and width helpers for the layer input packer.
//                Holds the packer state encoding and the feature-counter
//                width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package layer_io_pkg;

    // Packer states: FILL collects features, DROP discards an over-long
    // vector up to and including its in_last beat.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_DROP = 1'b1
    } pack_state_e;

    // Default vector length and the counter width that goes with it.
    localparam int DEFAULT_NUM_FEAT = 16;
    localparam int CNT_W            = $clog2(DEFAULT_NUM_FEAT);

    // Counter width for an arbitrary vector length: CNT_W = $clog2(num_feat).
    // Vector length is at least 2, so the result is never zero.
    function automatic int cnt_width(input int num_feat);
        return (num_feat < 2) ? 1 : $clog2(num_feat);
    endfunction

endpackage : layer_io_pkg
`default_nettype wire

// File: rtl/layer_input_packer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_input_packer
//  Description : Collects a stream of quantized features (one per beat) into
//                a packed vector for the first neuron layer. Feature k lands
//                in out_data[k*FEAT_BITS +: FEAT_BITS]. Vectors whose in_last
//                marker does not line up with the final slot are discarded
//                and reported with a one-cycle frame_err pulse.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                in_valid   - feature present on in_data
//                in_ready   - packer accepts the feature this cycle
//                in_data    - quantized feature value [FEAT_BITS]
//                in_last    - final feature of a vector
//                out_valid  - packed vector presented downstream
//                out_ready  - downstream consumes the vector
//                out_data   - packed vector [NUM_FEAT*FEAT_BITS]
//                frame_err  - one-cycle pulse on a framing error
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_input_packer
    import layer_io_pkg::*;
#(
    parameter int FEAT_BITS = 2,
    parameter int NUM_FEAT  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS-1:0]          in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FEAT*FEAT_BITS-1:0] out_data,
    output logic                          frame_err
);

    localparam int                    VEC_W    = NUM_FEAT * FEAT_BITS;
    localparam int                    CNT_BITS = cnt_width(NUM_FEAT);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(NUM_FEAT - 1);

    generate
        if (NUM_FEAT < 2 || NUM_FEAT > 64) begin : g_bad_num_feat
            $error("layer_input_packer: NUM_FEAT must be in 2..64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pack_state_e         state_q,     state_d;
    logic [CNT_BITS-1:0] cnt_q,       cnt_d;
    logic [VEC_W-1:0]    acc_q,       acc_d;
    logic [VEC_W-1:0]    out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_err_q, frame_err_d;

    logic                w_in_ready;
    logic                w_in_fire;
    logic [VEC_W-1:0]    w_acc_wr;

    // Only the completing beat needs the output register; it is stalled
    // exactly when that register is full and not draining this cycle.
    assign w_in_ready = !((state_q == ST_FILL) && (cnt_q == CNT_LAST) &&
                          out_valid_q && !out_ready);
    assign w_in_fire  = in_valid && w_in_ready;

    always_comb begin
        // Accumulator with the incoming feature dropped into slot cnt.
        w_acc_wr = acc_q;
        w_acc_wr[int'(cnt_q) * FEAT_BITS +: FEAT_BITS] = in_data;

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        frame_err_d = 1'b0;

        if (w_in_fire) begin
            case (state_q)
                ST_FILL: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (in_last) begin
                            // Complete vector goes straight to the output
                            // register, bypassing the accumulator so the
                            // final feature costs no extra cycle.
                            out_valid_d = 1'b1;
                            out_data_d  = w_acc_wr;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_DROP;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        acc_d = w_acc_wr;
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                ST_DROP: begin
                    if (in_last) begin
                        state_d = ST_FILL;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule : layer_input_packer
`default_nettype wire

// File: tb/tb_layer_input_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_input_packer
//  Description : Scoreboard bench for layer_input_packer. Stimulus pushes the
//                expected vector into a queue; a monitor pops and compares on
//                every output transfer and checks output stability on stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_input_packer;

    localparam int FB = 2;
    localparam int NF = 16;
    localparam int VW = FB * NF;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [FB-1:0] in_data   = '0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    wire           in_ready;
    wire           out_valid;
    wire  [VW-1:0] out_data;
    wire           frame_err;

    layer_input_packer #(.FEAT_BITS(FB), .NUM_FEAT(NF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    int          ferr_seen = 0;
    bit          rnd_mode  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [VW-1:0] data_prev = '0;
    logic [VW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(data_prev));
            end
            if (frame_err) ferr_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got 0x%0h expected no vector", out_data);
                end else begin
                    chk("out_vec", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    // Random back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle_gap();
        int n = 0;
        if (rnd_mode) begin
            while ($urandom_range(0, 1) == 0 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    task automatic send_beat(input logic [FB-1:0] d, input logic last);
        int n    = 0;
        bit done = 1'b0;
        idle_gap();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 2000) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout: got in_ready=0 expected 1 within 2000 cycles");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [VW-1:0] v);
        exp_q.push_back(v);
        for (int k = 0; k < NF; k++) begin
            send_beat(v[k*FB +: FB], (k == NF - 1));
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0;
        logic [VW-1:0] vb;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  64'(out_data),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Features k mod 4 -> each byte is 3,2,1,0 = 0xE4.
        out_ready = 1'b1;
        exp_q.push_back(32'hE4E4_E4E4);
        for (int k = 0; k < NF; k++) send_beat(FB'(k % 4), (k == NF - 1));
        chk("lat_valid", 64'(out_valid), 64'd1);
        drain("drain_basic");
        chk("ferr_basic", 64'(ferr_seen), 64'd0);

        // Two vectors against a stalled output.
        out_ready = 1'b0;
        send_vec(32'hDEAD_BEEF);
        vb = 32'h0F1E_2D3C;
        exp_q.push_back(vb);
        for (int k = 0; k < NF - 1; k++) send_beat(vb[k*FB +: FB], 1'b0);
        in_valid = 1'b1;
        in_data  = vb[(NF-1)*FB +: FB];
        in_last  = 1'b1;
        @(negedge clk);
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(vb[(NF-1)*FB +: FB], 1'b1);
        drain("drain_stall");

        // Early in_last on beat 5.
        ferr0 = ferr_seen;
        for (int k = 0; k < 6; k++) send_beat(2'd3, (k == 5));
        chk("ferr_short_pulse", 64'(frame_err), 64'd1);
        send_vec(32'h5A5A_A5A5);
        drain("drain_short");
        chk("ferr_short_count", 64'(ferr_seen - ferr0), 64'd1);

        // 20 beats, in_last only on beat 19.
        ferr0 = ferr_seen;
        for (int k = 0; k < 20; k++) begin
            send_beat(FB'(k % 4), (k == 19));
            if (k == 15) chk("ferr_long_pulse", 64'(frame_err), 64'd1);
            if (k == 16) chk("ferr_long_one",   64'(frame_err), 64'd0);
        end
        send_vec(32'h1357_9BDF);
        drain("drain_long");
        chk("ferr_long_count", 64'(ferr_seen - ferr0), 64'd1);

        // Reset mid-vector with a vector still waiting in the output register.
        out_ready = 1'b0;
        send_vec(32'hCAFE_F00D);
        for (int k = 0; k < 8; k++) send_beat(2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data",  64'(out_data),  64'd0);
        chk("midrst_frame_err", 64'(frame_err), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_vec(32'h8421_7BDE);
        drain("drain_midrst");

        // Random valid/ready traffic.
        rnd_mode = 1'b1;
        for (int v = 0; v < 1000; v++) send_vec(VW'($urandom()));
        rnd_mode = 1'b0;
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_layer_input_packer
`default_nettype wire
